mem_stage: RTL and testbench

Memory-access stage controller for the pipelined LC-3b datapath. It sits between the memory pipeline register (upstream) and the write-back pipeline register (downstream). It turns the instruction held in the memory register into one or two memory transactions (LDR/LDB/STR/STB, or the two-access LDI/STI), formats load data for write-back, and asserts a pipeline-wide stall until the access completes.

---
 rtl/lc3b_types.sv | 41 ++++
 rtl/mem_byte_fmt.sv | 32 +++
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory stage: opcodes, word/mask types,
// memory-stage FSM state encoding and byte-enable constants.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [3:0] {
        op_br   = 4'h0,
        op_add  = 4'h1,
        op_ldb  = 4'h2,
        op_stb  = 4'h3,
        op_jsr  = 4'h4,
        op_and  = 4'h5,
        op_ldr  = 4'h6,
        op_str  = 4'h7,
        op_rti  = 4'h8,
        op_not  = 4'h9,
        op_ldi  = 4'hA,
        op_sti  = 4'hB,
        op_jmp  = 4'hC,
        op_shf  = 4'hD,
        op_lea  = 4'hE,
        op_trap = 4'hF
    } lc3b_opcode;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } mem_stage_state_t;

    localparam lc3b_mem_wmask BE_WORD = 2'b11;
    localparam lc3b_mem_wmask BE_LO   = 2'b01;
    localparam lc3b_mem_wmask BE_HI   = 2'b10;

    // Clear bit 0 so every access lands on a word boundary.
    function automatic lc3b_word word_align(input lc3b_word addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/mem_byte_fmt.sv
// Byte-op formatting for the memory stage (purely combinational).
// Ports:
//   addr_lsb     - bit 0 of the effective address (selects the byte lane)
//   rdata        - memory read data
//   src_lo       - low byte of the store-source register
//   ldb_data_c   - selected byte of rdata, sign-extended to 16 bits
//   stb_wdata_c  - store byte replicated into both lanes
//   stb_mask_c   - write mask for the addressed byte lane
module mem_byte_fmt
    import lc3b_types::*;
(
    input  logic          addr_lsb,
    input  lc3b_word      rdata,
    input  logic [7:0]    src_lo,
    output lc3b_word      ldb_data_c,
    output lc3b_word      stb_wdata_c,
    output lc3b_mem_wmask stb_mask_c
);

    // Odd address means the high byte lane.
    always_comb begin
        if (addr_lsb) begin
            ldb_data_c = {{8{rdata[15]}}, rdata[15:8]};
            stb_mask_c = BE_HI;
        end else begin
            ldb_data_c = {{8{rdata[7]}}, rdata[7:0]};
            stb_mask_c = BE_LO;
        end
        stb_wdata_c = {src_lo, src_lo};
    end

endmodule

// File: rtl/mem_stage.sv
// LC-3b memory-access stage controller. Converts the instruction in the
// memory pipeline register into one or two memory transactions, formats
// load data for write-back and stalls the pipeline until the access ends.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   in_valid          - memory register holds a live instruction
//   in_opcode         - instruction opcode
//   in_address        - effective address
//   in_src            - store-source register value
//   mem_resp          - memory transaction completes this cycle
//   mem_rdata         - memory read data
//   mem_read/mem_write- request strobes
//   mem_byte_enable   - write byte mask
//   mem_address       - word-aligned request address
//   mem_wdata         - write data
//   rdata_out         - formatted load result for write-back
//   stall             - freeze all pipeline registers
module mem_stage
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  lc3b_opcode    in_opcode,
    input  lc3b_word      in_address,
    input  lc3b_word      in_src,
    input  logic          mem_resp,
    input  lc3b_word      mem_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output lc3b_mem_wmask mem_byte_enable,
    output lc3b_word      mem_address,
    output lc3b_word      mem_wdata,
    output lc3b_word      rdata_out,
    output logic          stall
);

    mem_stage_state_t state, next_state;
    lc3b_word         ptr;
    logic             ptr_load;
    logic             mem_op;
    logic             indirect;
    logic             is_store;
    lc3b_word         ldb_data;
    lc3b_word         stb_wdata;
    lc3b_mem_wmask    stb_mask;

    assign mem_op   = in_valid && (in_opcode inside {op_ldr, op_ldb, op_str,
                                                     op_stb, op_ldi, op_sti});
    assign indirect = (in_opcode == op_ldi) || (in_opcode == op_sti);
    assign is_store = (in_opcode == op_str) || (in_opcode == op_stb);

    mem_byte_fmt u_byte_fmt (
        .addr_lsb    (in_address[0]),
        .rdata       (mem_rdata),
        .src_lo      (in_src[7:0]),
        .ldb_data_c  (ldb_data),
        .stb_wdata_c (stb_wdata),
        .stb_mask_c  (stb_mask)
    );

    // State and indirect pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FIRST;
            ptr   <= '0;
        end else begin
            state <= next_state;
            if (ptr_load) begin
                ptr <= mem_rdata;
            end
        end
    end

    // Next state and Mealy request/stall/result outputs.
    always_comb begin
        next_state      = state;
        ptr_load        = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_address     = '0;
        mem_wdata       = '0;
        rdata_out       = '0;
        stall           = 1'b0;

        case (state)
            FIRST: begin
                if (mem_op) begin
                    mem_address = word_align(in_address);
                    if (is_store) begin
                        mem_write = 1'b1;
                        if (in_opcode == op_stb) begin
                            mem_wdata       = stb_wdata;
                            mem_byte_enable = stb_mask;
                        end else begin
                            mem_wdata       = in_src;
                            mem_byte_enable = BE_WORD;
                        end
                    end else begin
                        // LDI/STI both read the pointer on their first access.
                        mem_read        = 1'b1;
                        mem_byte_enable = BE_WORD;
                    end

                    if (indirect) begin
                        stall = 1'b1;
                        if (mem_resp) begin
                            next_state = SECOND;
                            ptr_load   = 1'b1;
                        end
                    end else begin
                        stall = !mem_resp;
                        if (mem_resp) begin
                            if (in_opcode == op_ldb) begin
                                rdata_out = ldb_data;
                            end else if (in_opcode == op_ldr) begin
                                rdata_out = mem_rdata;
                            end
                        end
                    end
                end
            end

            SECOND: begin
                if (mem_op) begin
                    mem_address     = word_align(ptr);
                    mem_byte_enable = BE_WORD;
                    if (in_opcode == op_sti) begin
                        mem_write = 1'b1;
                        mem_wdata = in_src;
                    end else begin
                        mem_read = 1'b1;
                    end
                    stall = !mem_resp;
                    if (mem_resp && (in_opcode == op_ldi)) begin
                        rdata_out = mem_rdata;
                    end
                end
                if (mem_resp) begin
                    next_state = FIRST;
                end
            end

            default: next_state = FIRST;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import lc3b_types::*;

    typedef struct {
        logic          rd;
        logic          wr;
        lc3b_mem_wmask be;
        lc3b_word      addr;
        lc3b_word      wdata;
        lc3b_word      rdout;
        logic          stall;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    lc3b_opcode    in_opcode;
    lc3b_word      in_address;
    lc3b_word      in_src;
    logic          mem_resp;
    lc3b_word      mem_rdata;
    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_word      rdata_out;
    logic          stall;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_opcode       (in_opcode),
        .in_address      (in_address),
        .in_src          (in_src),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .rdata_out       (rdata_out),
        .stall           (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic rd, input logic wr, input lc3b_mem_wmask be,
                                input lc3b_word addr, input lc3b_word wdata,
                                input lc3b_word rdout, input logic stl);
        exp_t e;
        e.rd = rd; e.wr = wr; e.be = be; e.addr = addr;
        e.wdata = wdata; e.rdout = rdout; e.stall = stl;
        return e;
    endfunction

    // One cycle: drive after the edge, push expectation, pop and compare mid-cycle.
    task automatic step(input string tag, input logic rst, input logic v,
                        input lc3b_opcode op, input lc3b_word addr, input lc3b_word src,
                        input logic resp, input lc3b_word rdata,
                        input bit do_chk, input exp_t e);
        exp_t got;
        @(posedge clk);
        #1;
        reset = rst; in_valid = v; in_opcode = op; in_address = addr;
        in_src = src; mem_resp = resp; mem_rdata = rdata;
        if (do_chk) sb_q.push_back(e);
        @(negedge clk);
        if (do_chk) begin
            got = sb_q.pop_front();
            chk({tag, ".read"},  16'(mem_read),        16'(got.rd));
            chk({tag, ".write"}, 16'(mem_write),       16'(got.wr));
            chk({tag, ".be"},    16'(mem_byte_enable), 16'(got.be));
            chk({tag, ".addr"},  mem_address,          got.addr);
            chk({tag, ".wdata"}, mem_wdata,            got.wdata);
            chk({tag, ".rdout"}, rdata_out,            got.rdout);
            chk({tag, ".stall"}, 16'(stall),           16'(got.stall));
        end
    endtask

    exp_t idle;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_opcode = op_add; in_address = '0;
        in_src = '0; mem_resp = 1'b0; mem_rdata = '0;
        idle = mk(0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0);

        // Reset state
        step("rst0", 1, 0, op_add, 16'h0, 16'h0, 0, 16'h0, 0, idle);
        step("rst1", 1, 0, op_add, 16'h0, 16'h0, 0, 16'h0, 1, idle);
        step("idle_inval", 0, 0, op_ldr, 16'h3001, 16'h0, 1, 16'h1234, 1, idle);
        step("add_valid", 0, 1, op_add, 16'h3001, 16'h0, 1, 16'h1234, 1, idle);

        // LDR zero-wait
        step("ldr", 0, 1, op_ldr, 16'h3001, 16'h0, 1, 16'h1234, 1,
             mk(1, 0, 2'b11, 16'h3000, 16'h0000, 16'h1234, 0));
        // LDB high and low bytes
        step("ldb_hi", 0, 1, op_ldb, 16'h4005, 16'h0, 1, 16'h80FF, 1,
             mk(1, 0, 2'b11, 16'h4004, 16'h0000, 16'hFF80, 0));
        step("ldb_lo", 0, 1, op_ldb, 16'h4004, 16'h0, 1, 16'h80FF, 1,
             mk(1, 0, 2'b11, 16'h4004, 16'h0000, 16'hFFFF, 0));
        step("ldb_lo_pos", 0, 1, op_ldb, 16'h4004, 16'h0, 1, 16'h807F, 1,
             mk(1, 0, 2'b11, 16'h4004, 16'h0000, 16'h007F, 0));

        // STB with 3-cycle response delay
        step("stb_c1", 0, 1, op_stb, 16'h2003, 16'h00AB, 0, 16'h0, 1,
             mk(0, 1, 2'b10, 16'h2002, 16'hABAB, 16'h0000, 1));
        step("stb_c2", 0, 1, op_stb, 16'h2003, 16'h00AB, 0, 16'h0, 1,
             mk(0, 1, 2'b10, 16'h2002, 16'hABAB, 16'h0000, 1));
        step("stb_c3", 0, 1, op_stb, 16'h2003, 16'h00AB, 1, 16'h0, 1,
             mk(0, 1, 2'b10, 16'h2002, 16'hABAB, 16'h0000, 0));
        step("stb_even", 0, 1, op_stb, 16'h2002, 16'h1234, 1, 16'h0, 1,
             mk(0, 1, 2'b01, 16'h2002, 16'h3434, 16'h0000, 0));

        // STR, odd address ignored
        step("str", 0, 1, op_str, 16'h2005, 16'hCAFE, 1, 16'h0, 1,
             mk(0, 1, 2'b11, 16'h2004, 16'hCAFE, 16'h0000, 0));

        // LDI zero-wait
        step("ldi_c1", 0, 1, op_ldi, 16'h1000, 16'h0, 1, 16'h5000, 1,
             mk(1, 0, 2'b11, 16'h1000, 16'h0000, 16'h0000, 1));
        step("ldi_c2", 0, 1, op_ldi, 16'h1000, 16'h0, 1, 16'hBEEF, 1,
             mk(1, 0, 2'b11, 16'h5000, 16'h0000, 16'hBEEF, 0));

        // STI zero-wait, odd pointer
        step("sti_c1", 0, 1, op_sti, 16'h1000, 16'h7777, 1, 16'h6001, 1,
             mk(1, 0, 2'b11, 16'h1000, 16'h0000, 16'h0000, 1));
        step("sti_c2", 0, 1, op_sti, 16'h1000, 16'h7777, 1, 16'h1111, 1,
             mk(0, 1, 2'b11, 16'h6000, 16'h7777, 16'h0000, 0));

        // LDI with 2-cycle latency per access: 3 stall cycles
        step("ldi2_c1", 0, 1, op_ldi, 16'h1002, 16'h0, 0, 16'h0, 1,
             mk(1, 0, 2'b11, 16'h1002, 16'h0000, 16'h0000, 1));
        step("ldi2_c2", 0, 1, op_ldi, 16'h1002, 16'h0, 1, 16'h5002, 1,
             mk(1, 0, 2'b11, 16'h1002, 16'h0000, 16'h0000, 1));
        step("ldi2_c3", 0, 1, op_ldi, 16'h1002, 16'h0, 0, 16'h0, 1,
             mk(1, 0, 2'b11, 16'h5002, 16'h0000, 16'h0000, 1));
        step("ldi2_c4", 0, 1, op_ldi, 16'h1002, 16'h0, 1, 16'h0042, 1,
             mk(1, 0, 2'b11, 16'h5002, 16'h0000, 16'h0042, 0));

        // Reset while in SECOND of an LDI
        step("ldi3_c1", 0, 1, op_ldi, 16'h1000, 16'h0, 1, 16'h5000, 1,
             mk(1, 0, 2'b11, 16'h1000, 16'h0000, 16'h0000, 1));
        step("ldi3_rst", 1, 1, op_ldi, 16'h1000, 16'h0, 1, 16'h9999, 0, idle);
        step("post_rst_add", 0, 1, op_add, 16'h1000, 16'h0, 0, 16'h0, 1, idle);
        step("post_rst_ldr", 0, 1, op_ldr, 16'h3001, 16'h0, 1, 16'hABCD, 1,
             mk(1, 0, 2'b11, 16'h3000, 16'h0000, 16'hABCD, 0));

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
